// File: rtl/acc_req_arbiter_if.sv
// acc_req_arbiter_if
//   Bundles every bus signal of the accelerator request arbiter: the
//   NumReq-wide requester side (mst_*), the single accelerator side (slv_*)
//   and the status outputs. Signal suffixes (_i/_o) are named from the
//   arbiter's point of view.
//   Modports:
//     slave  - the arbiter itself (it serves the requesters).
//     master - the surrounding system: requesters plus accelerator.
//   Parameters must match those given to the acc_req_arbiter instance.
interface acc_req_arbiter_if #(
  parameter int NumReq         = 4,
  parameter int DataWidth      = 32,
  parameter int IdWidth        = 5,
  parameter int MaxOutstanding = 4
);
  localparam int IdxWidth   = $clog2(NumReq);
  localparam int ExtIdWidth = IdWidth + IdxWidth;
  localparam int CntWidth   = $clog2(MaxOutstanding + 1);

  // Requester-side request channel
  logic [NumReq-1:0]           mst_q_valid_i;
  logic [NumReq-1:0]           mst_q_ready_o;
  logic [NumReq*DataWidth-1:0] mst_q_data_i;
  logic [NumReq*IdWidth-1:0]   mst_q_id_i;
  // Accelerator-side request channel
  logic                        slv_q_valid_o;
  logic                        slv_q_ready_i;
  logic [DataWidth-1:0]        slv_q_data_o;
  logic [ExtIdWidth-1:0]       slv_q_id_o;
  // Accelerator-side response channel
  logic                        slv_p_valid_i;
  logic                        slv_p_ready_o;
  logic [DataWidth-1:0]        slv_p_data_i;
  logic [ExtIdWidth-1:0]       slv_p_id_i;
  // Requester-side response channel
  logic [NumReq-1:0]           mst_p_valid_o;
  logic [NumReq-1:0]           mst_p_ready_i;
  logic [DataWidth-1:0]        mst_p_data_o;
  logic [IdWidth-1:0]          mst_p_id_o;
  // Status
  logic [CntWidth-1:0]         outstanding_o;
  logic                        rsp_err_o;

  modport slave (
    input  mst_q_valid_i, mst_q_data_i, mst_q_id_i,
    output mst_q_ready_o,
    output slv_q_valid_o, slv_q_data_o, slv_q_id_o,
    input  slv_q_ready_i,
    input  slv_p_valid_i, slv_p_data_i, slv_p_id_i,
    output slv_p_ready_o,
    output mst_p_valid_o, mst_p_data_o, mst_p_id_o,
    input  mst_p_ready_i,
    output outstanding_o, rsp_err_o
  );

  modport master (
    output mst_q_valid_i, mst_q_data_i, mst_q_id_i,
    input  mst_q_ready_o,
    input  slv_q_valid_o, slv_q_data_o, slv_q_id_o,
    output slv_q_ready_i,
    output slv_p_valid_i, slv_p_data_i, slv_p_id_i,
    input  slv_p_ready_o,
    input  mst_p_valid_o, mst_p_data_o, mst_p_id_o,
    output mst_p_ready_i,
    input  outstanding_o, rsp_err_o
  );
endinterface

// File: rtl/acc_req_arbiter.sv
// acc_req_arbiter
//   Shares one accelerator port among NumReq requesters. Requests are
//   picked round-robin and captured in a one-entry output register; the
//   requester index is prepended to the request ID so that responses can be
//   steered back combinationally by the upper ID bits. An outstanding
//   counter stops issue once MaxOutstanding requests are unanswered.
//   Ports:
//     clk_i - clock
//     rst_i - synchronous active-high reset
//     bus   - acc_req_arbiter_if.slave: requester request/response
//             channels, accelerator request/response channels,
//             outstanding_o count and rsp_err_o (bad response index).
module acc_req_arbiter #(
  parameter int NumReq         = 4,
  parameter int DataWidth      = 32,
  parameter int IdWidth        = 5,
  parameter int MaxOutstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  acc_req_arbiter_if.slave  bus
);
  localparam int IdxWidth   = $clog2(NumReq);
  localparam int ExtIdWidth = IdWidth + IdxWidth;
  localparam int CntWidth   = $clog2(MaxOutstanding + 1);

  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  q_valid_q, q_valid_d;
  logic [DataWidth-1:0]  q_data_q, q_data_d;
  logic [ExtIdWidth-1:0] q_id_q, q_id_d;

  // Unpacked per-requester views of the flat request buses.
  logic [DataWidth-1:0] req_data [NumReq];
  logic [IdWidth-1:0]   req_id   [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign req_data[gi] = bus.mst_q_data_i[gi*DataWidth +: DataWidth];
    assign req_id[gi]   = bus.mst_q_id_i[gi*IdWidth +: IdWidth];
  end

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic                can_issue;
  logic                gnt_found;
  logic                grant;
  logic [IdxWidth-1:0] gnt_idx;
  logic [IdxWidth-1:0] scan_idx;

  always_comb begin
    // The output slot is free if empty or being drained this very cycle.
    can_issue = (!q_valid_q || bus.slv_q_ready_i) &&
                (cnt_q < CntWidth'(MaxOutstanding));
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = ptr_q;
    // Walk all requesters starting at the pointer; explicit wrap keeps
    // non-power-of-two NumReq correct.
    for (int i = 0; i < NumReq; i++) begin
      if (!gnt_found && bus.mst_q_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
      scan_idx = (scan_idx == IdxWidth'(NumReq - 1)) ? '0
                                                     : scan_idx + IdxWidth'(1);
    end
  end

  assign grant = can_issue && gnt_found;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_q_ready
    assign bus.mst_q_ready_o[gi] = grant && (gnt_idx == IdxWidth'(gi));
  end

  // ---------------------------------------------------------------------
  // Response routing (purely combinational)
  // ---------------------------------------------------------------------
  logic [IdxWidth-1:0] rsp_idx;
  logic                rsp_idx_ok;
  logic [NumReq-1:0]   rsp_oh;
  logic                p_ready;
  logic                rsp_dec;

  assign rsp_idx = bus.slv_p_id_i[ExtIdWidth-1:IdWidth];
  // One extra bit so the bound check is meaningful for power-of-two NumReq.
  assign rsp_idx_ok = {1'b0, rsp_idx} < (IdxWidth + 1)'(NumReq);

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_rsp_oh
    assign rsp_oh[gi] = rsp_idx_ok && (rsp_idx == IdxWidth'(gi));
  end

  // Responses with an impossible index are swallowed so the slave never
  // stalls on them.
  assign p_ready           = rsp_idx_ok ? |(bus.mst_p_ready_i & rsp_oh) : 1'b1;
  assign rsp_dec           = bus.slv_p_valid_i && p_ready && rsp_idx_ok;
  assign bus.slv_p_ready_o = p_ready;
  assign bus.mst_p_valid_o = {NumReq{bus.slv_p_valid_i}} & rsp_oh;
  assign bus.mst_p_data_o  = bus.slv_p_data_i;
  assign bus.mst_p_id_o    = bus.slv_p_id_i[IdWidth-1:0];
  assign bus.rsp_err_o     = bus.slv_p_valid_i && !rsp_idx_ok;

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    ptr_d     = ptr_q;
    q_valid_d = q_valid_q;
    q_data_d  = q_data_q;
    q_id_d    = q_id_q;
    cnt_d     = cnt_q;

    if (grant) begin
      q_valid_d = 1'b1;
      q_data_d  = req_data[gnt_idx];
      q_id_d    = {gnt_idx, req_id[gnt_idx]};
      ptr_d     = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0
                                                     : gnt_idx + IdxWidth'(1);
    end else if (q_valid_q && bus.slv_q_ready_i) begin
      q_valid_d = 1'b0;
    end

    // can_issue already keeps a grant from overflowing the counter; the
    // zero check covers responses that arrive after a reset.
    if (grant && !rsp_dec) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!grant && rsp_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      q_valid_q <= 1'b0;
      q_data_q  <= '0;
      q_id_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      q_valid_q <= q_valid_d;
      q_data_q  <= q_data_d;
      q_id_q    <= q_id_d;
    end
  end

  assign bus.slv_q_valid_o = q_valid_q;
  assign bus.slv_q_data_o  = q_data_q;
  assign bus.slv_q_id_o    = q_id_q;
  assign bus.outstanding_o = cnt_q;
endmodule

// File: doc/acc_req_arbiter.md
Name: acc_req_arbiter

Overview:
- Shares one accelerator port among NumReq requesters.
- Round-robin arbitration with a one-entry registered request stage.
- Extends the request ID with the requester index, and routes responses back to the requester by the upper ID bits.
- Throttles issue with an outstanding-transaction counter. Sits in front of a single slave in the accelerator interconnect.

Parameters:
- NumReq, 4, number of requesters (>=2).
- DataWidth, 32, operand/result width.
- IdWidth, 5, requester-side ID width.
- MaxOutstanding, 4, max granted-but-unanswered requests (>=1).
- Derived IdxWidth = clog2(NumReq); ExtIdWidth = IdWidth+IdxWidth; CntWidth = clog2(MaxOutstanding+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- mst_q_valid_i  in  NumReq  per-requester request valid.
- mst_q_ready_o  out  NumReq  per-requester request accept (one-hot or zero).
- mst_q_data_i  in  NumReq*DataWidth  request operand, slice k = requester k.
- mst_q_id_i  in  NumReq*IdWidth  request ID, slice k.
- slv_q_valid_o  out  1  registered request valid to accelerator.
- slv_q_ready_i  in  1  accelerator accepts request.
- slv_q_data_o  out  DataWidth  registered operand.
- slv_q_id_o  out  ExtIdWidth  {grant index, requester ID}.
- slv_p_valid_i  in  1  response valid from accelerator.
- slv_p_ready_o  out  1  response accept.
- slv_p_data_i  in  DataWidth  result.
- slv_p_id_i  in  ExtIdWidth  extended response ID.
- mst_p_valid_o  out  NumReq  one-hot response valid.
- mst_p_ready_i  in  NumReq  per-requester response ready.
- mst_p_data_o  out  DataWidth  result, broadcast.
- mst_p_id_o  out  IdWidth  slv_p_id_i[IdWidth-1:0], broadcast.
- outstanding_o  out  CntWidth  current outstanding count.
- rsp_err_o  out  1  one-cycle pulse on a response with index >= NumReq.

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - Output register empties; slv_q_valid_o=0, slv_q_data_o=0, slv_q_id_o=0.
  - RR pointer=0, counter=0, rsp_err_o=0.
  - Combinational outputs follow from the empty/zero state.
  - Reset mid-operation discards the buffered request and all outstanding accounting. Responses arriving later are routed normally by ID; the counter saturates at 0 on them.
- Issue permission: can_issue = (!slv_q_valid_o || slv_q_ready_i) && (outstanding_o < MaxOutstanding). The free-slot check uses the same cycle's slv_q_ready_i (pass-through drain).
- Arbitration (combinational):
  - Scan mst_q_valid_i starting at RR pointer, wrapping modulo NumReq.
  - First valid index g wins if can_issue. mst_q_ready_o[g]=1, all other bits 0.
  - mst_q_ready_o=0 entirely when !can_issue or no valid requester.
  - mst_q_ready_o never depends on mst_q_ready-side handshakes of other requesters.
- On grant (valid&ready of g) at clk edge:
  - Register loads slv_q_data_o = data slice g and slv_q_id_o = {g, id slice g}; slv_q_valid_o=1.
  - RR pointer <= (g+1) mod NumReq. NumReq not a power of two: explicit wrap from NumReq-1 to 0.
- Slave handshake (slv_q_valid_o && slv_q_ready_i) with no new grant: slv_q_valid_o <= 0. Register contents hold stable while valid && !ready.
- Latency: grant at cycle N, slv_q_valid_o high from N+1. Sustained throughput is one request per cycle when slv_q_ready_i=1 and below the limit.
- Outstanding counter:
  - +1 on grant.
  - -1 on response handshake (slv_p_valid_i && slv_p_ready_o) with valid index.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding; decrement at 0 holds 0.
- Response routing:
  - idx = slv_p_id_i[ExtIdWidth-1:IdWidth].
  - idx < NumReq: mst_p_valid_o = onehot(idx) gated by slv_p_valid_i, and slv_p_ready_o = mst_p_ready_i[idx].
  - idx >= NumReq: mst_p_valid_o=0, slv_p_ready_o=1 (drop), rsp_err_o=1 that cycle, counter unchanged.
  - Response path is purely combinational, zero latency.
- Every accepted request is expected to produce exactly one response.

Test Plan:
- Reset then single request: requester 2 valid with data=0xDEADBEEF, id=5 and slv_q_ready_i=1 -> mst_q_ready_o=4'b0100 in cycle 0; next cycle slv_q_valid_o=1, slv_q_data_o=0xDEADBEEF, slv_q_id_o={2'd2,5'd5}; pointer=3, outstanding_o=1.
- All 4 requesters valid continuously, slave always ready, responses returned immediately -> grant order 0,1,2,3,0,1,... and each requester granted once per 4 cycles.
- Backpressure: slv_q_ready_i=0 for 3 cycles with the register full -> mst_q_ready_o=0, slv_q_data_o/slv_q_id_o stable. With slv_q_ready_i=1 and requester 1 valid, drain and new grant happen in the same cycle, and slv_q_valid_o stays 1.
- Outstanding limit: MaxOutstanding=4, no responses; 4 grants -> outstanding_o=4, then mst_q_ready_o=0. A single response with id={2'd1,5'd7} gives mst_p_valid_o=4'b0010 and mst_p_id_o=7; on handshake outstanding_o=3 and one grant proceeds. With simultaneous grant and response, outstanding_o stays unchanged.
- NumReq=3, response with idx=3 -> slv_p_ready_o=1, mst_p_valid_o=0, rsp_err_o pulses 1 cycle, counter unchanged. RR wrap: grant 2 sets pointer to 0.
- Reset asserted while the register is full and outstanding_o=2 -> next cycle slv_q_valid_o=0, outstanding_o=0, pointer=0. A late response with valid idx is routed and the counter stays 0.
